// File: rtl/audio_pkg.sv
// Shared definitions for the audio DAC transmit path.
//   AUDIO_DATA_WIDTH : native sample width of the codec path
//   stereo_sample_t  : one left/right sample pair
//   ser_state_t      : serializer channel-tracking state
//   fall_edge/rise_edge : edge detect on a synchronized level and its history
package audio_pkg;

    localparam int AUDIO_DATA_WIDTH = 24;

    typedef struct packed {
        logic [AUDIO_DATA_WIDTH-1:0] left;
        logic [AUDIO_DATA_WIDTH-1:0] right;
    } stereo_sample_t;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2
    } ser_state_t;

    function automatic logic fall_edge(input logic hist, input logic cur);
        return hist & ~cur;
    endfunction

    function automatic logic rise_edge(input logic hist, input logic cur);
        return ~hist & cur;
    endfunction

endpackage

// File: rtl/audio_dac_serializer_if.sv
// Write-side handshake into the DAC serializer.
//   write            : writer offers one stereo pair this cycle
//   writedata_left   : left sample, two's complement
//   writedata_right  : right sample, two's complement
//   write_ready      : serializer can take a pair (accepted on write && write_ready)
// master = sample producer, slave = serializer.
interface audio_dac_serializer_if
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = AUDIO_DATA_WIDTH
);

    logic                  write;
    logic [DATA_WIDTH-1:0] writedata_left;
    logic [DATA_WIDTH-1:0] writedata_right;
    logic                  write_ready;

    modport master (
        output write,
        output writedata_left,
        output writedata_right,
        input  write_ready
    );

    modport slave (
        input  write,
        input  writedata_left,
        input  writedata_right,
        output write_ready
    );

endinterface

// File: rtl/audio_dac_serializer_fifo.sv
// Synchronous FIFO of packed stereo pairs, first-word-fall-through read.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   push/wdata : write request and entry; ignored when full unless a pop
//                happens in the same cycle
//   pop/rdata  : read request and head entry; pop while empty is ignored
//   full/empty/count : occupancy status
module sample_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_r == (AW+1)'(DEPTH));
    assign empty = (count_r == (AW+1)'(0));
    assign count = count_r;
    assign rdata = mem_r[rd_ptr_r];

    // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S transmit serializer for the WM8731 DAC half of the codec interface.
// Stereo pairs arrive over dac_in, are buffered, and shifted out MSB-first on
// AUD_DACDAT with the one-BCLK I2S delay, slaved to the codec's BCLK/DACLRCK.
//   CLOCK_50     : system clock, all logic on its rising edge
//   reset        : synchronous active-high reset
//   dac_in       : write/writedata_left/writedata_right/write_ready handshake
//   AUD_BCLK     : codec bit clock (asynchronous, sampled here)
//   AUD_DACLRCK  : codec frame clock (asynchronous), low = left, high = right
//   AUD_DACDAT   : serial data to the codec
//   underflow    : one-cycle pulse when a frame starts with nothing buffered
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = AUDIO_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    audio_dac_serializer_if.slave dac_in,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT,
    output logic                  underflow
);

    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] BIT_CNT_MAX = CNT_W'(DATA_WIDTH);

    logic bclk_meta_r, bclk_sync_r, bclk_hist_r;
    logic lrck_meta_r, lrck_sync_r, lrck_hist_r;
    logic bclk_fall_s, lrck_fall_s, lrck_rise_s;

    ser_state_t state_r, state_nxt_s;
    logic       load_left_s, load_right_s, pop_req_s;

    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] hold_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic                  dacdat_r;
    logic                  underflow_r;
    logic                  write_ready_r;

    logic                    fifo_push_s;
    logic                    fifo_pop_s;
    logic [2*DATA_WIDTH-1:0] fifo_rdata_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [FIFO_AW:0]        fifo_count_s;

    assign AUD_DACDAT         = dacdat_r;
    assign underflow          = underflow_r;
    assign dac_in.write_ready = write_ready_r;

    // Two-flop synchronizers plus a history flop for edge detection on BCLK and DACLRCK.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            {bclk_hist_r, bclk_sync_r, bclk_meta_r} <= 3'b000;
            {lrck_hist_r, lrck_sync_r, lrck_meta_r} <= 3'b000;
        end else begin
            {bclk_hist_r, bclk_sync_r, bclk_meta_r} <= {bclk_sync_r, bclk_meta_r, AUD_BCLK};
            {lrck_hist_r, lrck_sync_r, lrck_meta_r} <= {lrck_sync_r, lrck_meta_r, AUD_DACLRCK};
        end
    end

    assign bclk_fall_s = fall_edge(bclk_hist_r, bclk_sync_r);
    assign lrck_fall_s = fall_edge(lrck_hist_r, lrck_sync_r);
    assign lrck_rise_s = rise_edge(lrck_hist_r, lrck_sync_r);

    // Only request a pop when something is buffered; the empty case becomes an underflow.
    assign fifo_push_s = dac_in.write & write_ready_r;
    assign fifo_pop_s  = pop_req_s & (fifo_count_s != (FIFO_AW+1)'(0));

    sample_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLOCK_50),
        .reset (reset),
        .push  (fifo_push_s),
        .wdata ({dac_in.writedata_left, dac_in.writedata_right}),
        .pop   (fifo_pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Ready mirrors the FIFO full flag one cycle late.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            write_ready_r <= 1'b1;
        end else begin
            write_ready_r <= ~fifo_full_s;
        end
    end

    // Channel state register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r <= WAIT_SYNC;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Channel tracking: every DACLRCK falling edge starts a left channel (so the
    // block never starts on a right channel); a rising edge after a left starts the right.
    always_comb begin
        state_nxt_s  = state_r;
        load_left_s  = 1'b0;
        load_right_s = 1'b0;
        pop_req_s    = 1'b0;
        case (state_r)
            WAIT_SYNC: begin
                if (lrck_fall_s) begin
                    state_nxt_s = LEFT;
                    load_left_s = 1'b1;
                    pop_req_s   = 1'b1;
                end else begin
                    state_nxt_s = WAIT_SYNC;
                end
            end
            LEFT: begin
                if (lrck_rise_s) begin
                    state_nxt_s  = RIGHT;
                    load_right_s = 1'b1;
                end else if (lrck_fall_s) begin
                    state_nxt_s = LEFT;
                    load_left_s = 1'b1;
                    pop_req_s   = 1'b1;
                end else begin
                    state_nxt_s = LEFT;
                end
            end
            RIGHT: begin
                if (lrck_fall_s) begin
                    state_nxt_s = LEFT;
                    load_left_s = 1'b1;
                    pop_req_s   = 1'b1;
                end else begin
                    state_nxt_s = RIGHT;
                end
            end
            default: begin
                state_nxt_s = WAIT_SYNC;
            end
        endcase
    end

    // Shift datapath. A channel load takes priority over a coincident BCLK fall,
    // so the MSB goes out on the following fall (the I2S one-bit delay).
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            shift_r     <= '0;
            hold_r      <= '0;
            bit_cnt_r   <= '0;
            dacdat_r    <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            underflow_r <= 1'b0;
            if (load_left_s) begin
                bit_cnt_r <= '0;
                if (fifo_empty_s) begin
                    shift_r     <= '0;
                    hold_r      <= '0;
                    underflow_r <= 1'b1;
                end else begin
                    shift_r <= fifo_rdata_s[2*DATA_WIDTH-1:DATA_WIDTH];
                    hold_r  <= fifo_rdata_s[DATA_WIDTH-1:0];
                end
                if (bclk_fall_s) begin
                    dacdat_r <= 1'b0;
                end
            end else if (load_right_s) begin
                bit_cnt_r <= '0;
                shift_r   <= hold_r;
                if (bclk_fall_s) begin
                    dacdat_r <= 1'b0;
                end
            end else if (bclk_fall_s && (state_r != WAIT_SYNC)) begin
                if (bit_cnt_r != BIT_CNT_MAX) begin
                    dacdat_r  <= shift_r[DATA_WIDTH-1];
                    shift_r   <= {shift_r[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                end else begin
                    dacdat_r <= 1'b0;
                end
            end
        end
    end

endmodule
